// File: rtl/grid_loader.sv
// grid_loader: sequences a P_PARAM_M x P_PARAM_N grid initialisation into the
// generation RAM, one cell per cycle in row-major order (clear / glider / random).
// Optional feature macro: GRID_LOADER_RANDOM_EN enables the 16-bit LFSR and the
// random fill mode; without it mode 01 fills as clear and seed is ignored.
module grid_loader #(
    parameter int P_PARAM_M = 5,
    parameter int P_PARAM_N = 5,
    parameter int WIDTH     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_req,
    input  logic [1:0]           mode,
    input  logic [15:0]          seed,
    output logic                 wden,
    output logic [2*WIDTH-1:0]   write_pos,
    output logic                 write_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [1:0]       MODE_RANDOM = 2'b01;
    localparam logic [1:0]       MODE_GLIDER = 2'b10;
    localparam logic [WIDTH-1:0] LAST_ROW    = WIDTH'(P_PARAM_M - 1);
    localparam logic [WIDTH-1:0] LAST_COL    = WIDTH'(P_PARAM_N - 1);
    localparam logic [WIDTH-1:0] IDX0        = WIDTH'(0);
    localparam logic [WIDTH-1:0] IDX1        = WIDTH'(1);
    localparam logic [WIDTH-1:0] IDX2        = WIDTH'(2);

    state_t           state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] row, col;
    logic [WIDTH-1:0] nxt_row, nxt_col;
    logic             last_cell;
    logic             prev_load_req;
    logic             load_edge;
    logic             first_data;
    logic             next_data;

    // Glider pattern anchored at the origin; cells beyond a small grid never occur.
    function automatic logic fill_value(input logic [1:0] m,
                                        input logic [WIDTH-1:0] r,
                                        input logic [WIDTH-1:0] c);
        if (m == MODE_GLIDER)
            return (r == IDX0 && c == IDX1) ||
                   (r == IDX1 && c == IDX2) ||
                   (r == IDX2 && (c == IDX0 || c == IDX1 || c == IDX2));
        return 1'b0;
    endfunction

    // Request edge detector history; runs through reset so a held request cannot fire on release.
    always_ff @(posedge clk) begin
        prev_load_req <= load_req;
    end

    assign load_edge = load_req & ~prev_load_req;

    // Next raster position and end-of-grid detection.
    always_comb begin
        last_cell = (row == LAST_ROW) && (col == LAST_COL);
        nxt_row   = row;
        nxt_col   = col + IDX1;
        if (col == LAST_COL) begin
            nxt_col = IDX0;
            nxt_row = row + IDX1;
        end
    end

`ifdef GRID_LOADER_RANDOM_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [15:0] seed_eff;

    // Right-shifting Fibonacci form of taps 16,14,13,11; bit 0 is the output.
    assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign seed_eff = (seed == 16'h0000) ? 16'hACE1 : seed;

    // LFSR holds the value whose bit 0 is the cell currently being written.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (state == S_IDLE && load_edge)
            lfsr <= seed_eff;
        else if (state == S_FILL)
            lfsr <= lfsr_nxt;
    end

    // Cell value for the first write (from live inputs) and for the following write.
    always_comb begin
        first_data = fill_value(mode, IDX0, IDX0);
        next_data  = fill_value(mode_q, nxt_row, nxt_col);
        if (mode == MODE_RANDOM)
            first_data = seed_eff[0];
        if (mode_q == MODE_RANDOM)
            next_data = lfsr_nxt[0];
    end
`else
    logic unused_seed;
    assign unused_seed = ^seed;

    // Cell value for the first write (from live inputs) and for the following write.
    always_comb begin
        first_data = fill_value(mode, IDX0, IDX0);
        next_data  = fill_value(mode_q, nxt_row, nxt_col);
    end
`endif

    // Load sequencer with registered write strobe, address, data and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_q     <= 2'b00;
            row        <= '0;
            col        <= '0;
            wden       <= 1'b0;
            write_pos  <= '0;
            write_data <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (load_edge) begin
                        mode_q     <= mode;
                        row        <= '0;
                        col        <= '0;
                        wden       <= 1'b1;
                        write_pos  <= '0;
                        write_data <= first_data;
                        busy       <= 1'b1;
                        state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (last_cell) begin
                        wden       <= 1'b0;
                        write_data <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        row        <= nxt_row;
                        col        <= nxt_col;
                        write_pos  <= write_pos + 1'b1;
                        write_data <= next_data;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    wden  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The incremental address must always equal row*P_PARAM_N+col.
    always_ff @(posedge clk) begin
        if (!rst && wden)
            assert (write_pos == (2*WIDTH)'(row) * (2*WIDTH)'(P_PARAM_N) + (2*WIDTH)'(col))
                else $error("grid_loader: write_pos out of step with row/col");
    end
`endif

endmodule

// File: tb/tb_grid_loader.sv
// Directed bench for grid_loader at M=N=5: clear, glider, random, mode 11,
// reset abort, reset/request collision and ignored/held requests.
module tb_grid_loader;

    localparam int M = 5;
    localparam int N = 5;
    localparam int W = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_req = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [15:0]     seed = 16'h0000;
    logic            wden;
    logic [2*W-1:0]  write_pos;
    logic            write_data;
    logic            busy;
    logic            done;

    int vectors = 0;
    int miscompares = 0;

    grid_loader #(.P_PARAM_M(M), .P_PARAM_N(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .mode       (mode),
        .seed       (seed),
        .wden       (wden),
        .write_pos  (write_pos),
        .write_data (write_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference LFSR: taps 16,14,13,11, output bit 0, seed 0 replaced by ACE1.
    function automatic logic [24:0] random_bits(input logic [15:0] s);
        logic [15:0] l;
        logic [24:0] b;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        b = '0;
        for (int i = 0; i < 25; i++) begin
            b[i] = l[0];
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        return b;
    endfunction

    // One full load; optionally raise a second request edge at cell reedge_at (left high).
    task automatic run_load(input string tag, input logic [1:0] m, input logic [15:0] s,
                            input logic [24:0] exp, input int reedge_at);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_wden"}, 32'(wden), 0);
        mode = m;
        seed = s;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        mode = m ^ 2'b11;
        seed = ~s;
        for (int i = 0; i < M * N; i++) begin
            if (i == reedge_at)
                load_req = 1'b1;
            check({tag, "_wden"}, 32'(wden), 1);
            check({tag, "_pos"}, 32'(write_pos), 32'(i));
            check({tag, "_data"}, 32'(write_data), 32'(exp[i]));
            check({tag, "_busy"}, 32'(busy), 1);
            check({tag, "_done_early"}, 32'(done), 0);
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_end_wden"}, 32'(wden), 0);
        check({tag, "_end_busy"}, 32'(busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_post_wden"}, 32'(wden), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [24:0] glider_exp;
        logic [24:0] rnd_exp0;
        logic [24:0] rnd_exp1;
        logic [24:0] rnd_expa;
        int          n;
        int          strobes;

        glider_exp = 25'h0001C82;
`ifdef GRID_LOADER_RANDOM_EN
        rnd_exp0 = random_bits(16'h0000);
        rnd_expa = random_bits(16'hACE1);
        rnd_exp1 = random_bits(16'h1234);
        // Hand-stepped from ACE1: E1->bit0 1, 5670->0, AB38->0, 559C->0.
        check("lfsr_ref_head", 32'(rnd_exp0[3:0]), 32'h1);
`else
        rnd_exp0 = '0;
        rnd_expa = '0;
        rnd_exp1 = '0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wden", 32'(wden), 0);
        check("rst_pos", 32'(write_pos), 0);
        check("rst_data", 32'(write_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;

        run_load("clear", 2'b00, 16'h0000, 25'h0, -1);
        run_load("glider", 2'b10, 16'h0000, glider_exp, -1);
        run_load("rand_s0", 2'b01, 16'h0000, rnd_exp0, -1);
        run_load("rand_sace1", 2'b01, 16'hACE1, rnd_expa, -1);
        check("rand_same_seq", 32'(rnd_exp0), 32'(rnd_expa));
        run_load("rand_s1234", 2'b01, 16'h1234, rnd_exp1, -1);
        run_load("mode11", 2'b11, 16'hFFFF, 25'h0, -1);

        // Reset abort at write_pos 13
        @(negedge clk);
        mode = 2'b00;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        n = 0;
        while (write_pos != 24'd13 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach13", 32'(write_pos), 13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_wden", 32'(wden), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_pos", 32'(write_pos), 0);
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wden || done) strobes++;
        end
        check("abort_quiet", 32'(strobes), 0);
        run_load("restart", 2'b10, 16'h0000, glider_exp, -1);

        // Reset wins over a simultaneous request edge; held request does not fire on release
        @(negedge clk);
        rst = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstpri_wden", 32'(wden), 0);
        check("rstpri_busy", 32'(busy), 0);
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wden || busy) strobes++;
        end
        check("rstpri_held", 32'(strobes), 0);
        load_req = 1'b0;

        // Second edge at write_pos 5 ignored; request then held high past done
        run_load("reedge", 2'b00, 16'h0000, 25'h0, 5);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wden || busy || done) strobes++;
        end
        check("held_no_retrigger", 32'(strobes), 0);
        load_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grid_loader.md
GRID_LOADER -- requirements
Module: grid_loader

Interface
REQ-001 Parameters SHALL be: P_PARAM_M, default 5, grid rows; P_PARAM_N, default 5, grid columns; WIDTH, default 12, coordinate width.
REQ-002 Clocking and reset SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk SHALL be an input, 1 bit wide: the global clock, with all logic on its rising edge.
REQ-004 rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-005 load_req SHALL be an input, 1 bit wide: level request; a load is accepted on the rising edge of load_req.
REQ-006 mode SHALL be an input, 2 bits wide: 00 clear, 01 random, 10 glider, 11 treated as clear; sampled at acceptance.
REQ-007 seed SHALL be an input, 16 bits wide: LFSR seed, sampled at acceptance.
REQ-008 wden SHALL be an output, 1 bit wide: cell write strike to the generation RAM.
REQ-009 write_pos SHALL be an output, 2*WIDTH bits wide: linear cell index, row*P_PARAM_N+col.
REQ-010 write_data SHALL be an output, 1 bit wide: cell state to write (1 = live).
REQ-011 busy SHALL be an output, 1 bit wide: high while loading; the evolution stage is held off while busy.
REQ-012 done SHALL be an output, 1 bit wide: one-cycle pulse after the last write.

Function
REQ-013 The FSM SHALL have the states S_IDLE, S_FILL and S_DONE.
REQ-014 In S_IDLE, a load_req rising edge (prev_load_req==0 && load_req==1) SHALL latch mode and seed, clear the row/col counters and go to S_FILL.
REQ-015 In S_FILL, the block SHALL write one cell per cycle: wden=1, write_pos=row*P_PARAM_N+col, in row-major order from index 0 to P_PARAM_M*P_PARAM_N-1.
REQ-016 The col counter SHALL wrap at P_PARAM_N-1 and increment row; after writing (P_PARAM_M-1, P_PARAM_N-1) the FSM SHALL go to S_DONE.
REQ-017 write_pos SHALL be maintained incrementally (+1 per write) with no multiplier, and SHALL be checked equal to row*P_PARAM_N+col.
REQ-018 write_data SHALL be 0 in clear mode.
REQ-019 In glider mode, write_data SHALL be 1 exactly at (0,1), (1,2), (2,0), (2,1) and (2,2), and 0 elsewhere; cells outside the grid SHALL be silently dropped.
REQ-020 In random mode, write_data SHALL be lfsr[0]; the LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11 that advances once per write.
REQ-021 The LFSR SHALL load seed at acceptance, or 16'hACE1 when seed==0.
REQ-022 busy SHALL be 1 from the cycle after acceptance through the last write; wden SHALL never be 1 outside S_FILL.
REQ-023 In S_DONE, the block SHALL assert done for one cycle, drop busy and wden, and return to S_IDLE.
REQ-024 Latency SHALL be exactly P_PARAM_M*P_PARAM_N write cycles, with done one cycle after the last write.
REQ-025 A load_req edge while in S_FILL or S_DONE SHALL be ignored and SHALL NOT restart the load; a held-high load_req SHALL NOT retrigger.
REQ-026 prev_load_req SHALL update every cycle, including during rst.

Reset
REQ-027 rst SHALL force wden=0, write_pos=0, write_data=0, busy=0, done=0, row=col=0, lfsr=16'hACE1 and state S_IDLE.
REQ-028 rst asserted mid-load SHALL abort the load on that edge with no further write strobes, and SHALL NOT produce a done pulse.
REQ-029 rst SHALL take priority over a simultaneous load_req edge.

Configuration
REQ-030 The macro GRID_LOADER_RANDOM_EN SHALL control the random fill feature.
REQ-031 With GRID_LOADER_RANDOM_EN defined, the LFSR and random mode SHALL be present.
REQ-032 Without GRID_LOADER_RANDOM_EN, the LFSR SHALL be absent, mode 01 SHALL behave as clear, and seed SHALL be ignored.

Verification (M=N=5)
REQ-033 Clear scenario: load_req 0->1 with mode=00 -> 25 consecutive wden cycles with write_pos 0..24 and write_data 0, then a done pulse one cycle after write_pos 24, with busy high for exactly 25 cycles.
REQ-034 Glider scenario: mode=10 -> write_data 1 only at write_pos 1, 7, 10, 11 and 12, giving 5 live cells total.
REQ-035 Random scenario: mode=01 with seed=0 and then with seed=16'hACE1 -> identical 25-bit sequences that match the reference LFSR model.
REQ-036 Reset abort scenario: rst asserted at write_pos 13 -> wden=0 on the next cycle with no done pulse; a subsequent load restarts at write_pos 0.
REQ-037 Ignored request scenario: a second load_req edge at write_pos 5 and load_req held high after done -> exactly one load of 25 writes.
REQ-038 Configuration scenario: build without GRID_LOADER_RANDOM_EN, mode=01 -> all write_data 0.
